final_row_accumulator: RTL and testbench

- Downstream of the last processing element in the systolic array.
- Each haplotype column, the last PE emits its final-row M and I values. This block sums (M + I) over all columns of one read/haplotype pair to produce the pair's 64-bit IEEE-754 double likelihood.
- A small input FIFO decouples the PE advance rate from the multi-cycle double adder.
- The result is delivered to the host-side result path on a valid/ready handshake.

---
 rtl/final_row_accumulator_pkg.sv | 38 +++
 rtl/final_row_accumulator_add.sv | 159 +++++++++++++++
 rtl/final_row_accumulator.sv | 197 +++++++++++++++++++
 tb/tb_final_row_accumulator.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/final_row_accumulator_pkg.sv
// Shared types for the final-row likelihood accumulator.
// Column bundle, FSM state encodings and double constants.
package final_row_accumulator_pkg;

  localparam int VAL_W = 64;

  typedef logic [VAL_W-1:0] dbl_t;

  localparam dbl_t DBL_ZERO = 64'h0;
  localparam dbl_t DBL_QNAN = 64'h7FF8_0000_0000_0000;

  typedef struct packed {
    dbl_t m;
    dbl_t i;
  } col_t;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    ADD_MI,
    ADD_ACC,
    RESULT
  } fra_state_e;

  typedef enum logic [1:0] {
    PH_CLR,
    PH_ISSUE,
    PH_WAIT
  } op_phase_e;

  typedef enum logic [1:0] {
    A_IDLE,
    A_ALIGN,
    A_NORM,
    A_DONE
  } add_state_e;

endpackage

// File: rtl/final_row_accumulator_add.sv
// Multi-cycle IEEE-754 double adder, round-to-nearest-even.
// Done stays high until the synchronous clear.
module double_add
  import final_row_accumulator_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  dbl_t input_a,
  input  dbl_t input_b,
  input  logic input_valid,
  output dbl_t output_z,
  output logic output_done
);

  add_state_e  st_q, st_d;
  logic        spec_q;
  dbl_t        spec_z_q;
  logic        bs_q, ss_q;
  logic [11:0] be_q, d_q;
  logic [52:0] bm_q, sm_q;
  logic [56:0] sum_q;
  dbl_t        z_q;

  logic [10:0] ea, eb;
  logic [51:0] fa, fb;
  logic [11:0] ea_e, eb_e;
  logic [52:0] ma, mb;
  logic        a_big, inf_a, inf_b, nan_a, nan_b;
  dbl_t        spec_z_d;

  // Unpack operands, order by magnitude, resolve Inf/NaN early
  always_comb begin
    ea       = input_a[62:52];
    eb       = input_b[62:52];
    fa       = input_a[51:0];
    fb       = input_b[51:0];
    ea_e     = (ea == 11'd0) ? 12'd1 : {1'b0, ea};
    eb_e     = (eb == 11'd0) ? 12'd1 : {1'b0, eb};
    ma       = {ea != 11'd0, fa};
    mb       = {eb != 11'd0, fb};
    inf_a    = (ea == 11'h7FF) && (fa == 52'd0);
    inf_b    = (eb == 11'h7FF) && (fb == 52'd0);
    nan_a    = (ea == 11'h7FF) && (fa != 52'd0);
    nan_b    = (eb == 11'h7FF) && (fb != 52'd0);
    a_big    = input_a[62:0] >= input_b[62:0];
    spec_z_d = input_b;
    if (nan_a || nan_b)
      spec_z_d = DBL_QNAN;
    else if (inf_a && inf_b && (input_a[63] != input_b[63]))
      spec_z_d = DBL_QNAN;
    else if (inf_a)
      spec_z_d = input_a;
  end

  logic [5:0]   dcl;
  logic [111:0] ext;
  logic [55:0]  al;
  logic [56:0]  sum_d;

  // Align the smaller operand with sticky, then add or subtract
  always_comb begin
    dcl   = (d_q > 12'd60) ? 6'd60 : d_q[5:0];
    ext   = {sm_q, 3'b000, 56'd0} >> dcl;
    al    = ext[111:56] | {55'd0, |ext[55:0]};
    sum_d = (bs_q ^ ss_q)
          ? ({1'b0, bm_q, 3'b000} - {1'b0, al})
          : ({1'b0, bm_q, 3'b000} + {1'b0, al});
  end

  logic [5:0]  lz;
  logic [11:0] lim, sh, e_n, e_r;
  logic [55:0] nm;
  logic [53:0] m54;
  logic [52:0] mant;
  logic        rnd;
  dbl_t        z_d;

  // Normalise, round to nearest even, pack
  always_comb begin
    lz = 6'd56;
    for (int k = 0; k < 56; k++)
      if (sum_q[k]) lz = 6'(55 - k);
    lim = be_q - 12'd1;
    sh  = 12'd0;
    nm  = sum_q[55:0];
    e_n = be_q;
    if (sum_q[56]) begin
      nm  = {sum_q[56:2], sum_q[1] | sum_q[0]};
      e_n = be_q + 12'd1;
    end else begin
      sh  = ({6'd0, lz} > lim) ? lim : {6'd0, lz};
      nm  = sum_q[55:0] << sh;
      e_n = be_q - sh;
    end
    rnd  = nm[2] & (nm[1] | nm[0] | nm[3]);
    m54  = {1'b0, nm[55:3]} + {53'd0, rnd};
    mant = m54[52:0];
    e_r  = e_n;
    if (m54[53]) begin
      mant = m54[53:1];
      e_r  = e_n + 12'd1;
    end
    if (spec_q)
      z_d = spec_z_q;
    else if (sum_q == 57'd0)
      z_d = {bs_q & ss_q, 63'd0};
    else if (e_r >= 12'd2047)
      z_d = {bs_q, 11'h7FF, 52'd0};
    else
      z_d = {bs_q, mant[52] ? e_r[10:0] : 11'd0, mant[51:0]};
  end

  // Operation sequencing
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      A_IDLE:  if (input_valid) st_d = A_ALIGN;
      A_ALIGN: st_d = A_NORM;
      A_NORM:  st_d = A_DONE;
      A_DONE:  st_d = A_DONE;
      default: st_d = A_IDLE;
    endcase
  end

  // Pipeline registers with synchronous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q     <= A_IDLE;
      spec_q   <= 1'b0;
      spec_z_q <= DBL_ZERO;
      bs_q     <= 1'b0;
      ss_q     <= 1'b0;
      be_q     <= 12'd0;
      d_q      <= 12'd0;
      bm_q     <= 53'd0;
      sm_q     <= 53'd0;
      sum_q    <= 57'd0;
      z_q      <= DBL_ZERO;
    end else begin
      st_q <= st_d;
      if (st_q == A_IDLE && input_valid) begin
        spec_q   <= (ea == 11'h7FF) || (eb == 11'h7FF);
        spec_z_q <= spec_z_d;
        bs_q     <= a_big ? input_a[63] : input_b[63];
        ss_q     <= a_big ? input_b[63] : input_a[63];
        be_q     <= a_big ? ea_e : eb_e;
        bm_q     <= a_big ? ma : mb;
        sm_q     <= a_big ? mb : ma;
        d_q      <= a_big ? (ea_e - eb_e) : (eb_e - ea_e);
      end
      if (st_q == A_ALIGN) sum_q <= sum_d;
      if (st_q == A_NORM)  z_q   <= z_d;
    end
  end

  assign output_z    = z_q;
  assign output_done = (st_q == A_DONE);

endmodule

// File: rtl/final_row_accumulator.sv
// Sums final-row (M + I) over all columns of a pair into one double.
// Column FIFO in front of a single time-shared double adder.
module final_row_accumulator
  import final_row_accumulator_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int COL_W      = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [COL_W-1:0] num_cols,
  input  logic             col_valid,
  input  dbl_t             col_m,
  input  dbl_t             col_i,
  output logic             col_ready,
  output dbl_t             result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy,
  output logic             overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [1:0] rs_q;
  logic       rst_n;

  // Asynchronous assert, clock-synchronous release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rs_q <= 2'b00;
    else        rs_q <= {rs_q[0], 1'b1};
  end
  assign rst_n = rs_q[1];

  fra_state_e       state_q, state_d;
  op_phase_e        ph_q, ph_d;
  logic [COL_W-1:0] num_cols_q, acc_cnt_q, done_cnt_q;
  dbl_t             acc_q, sum_q, m_q, i_q, result_q;
  logic             ovf_q;
  col_t             mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;

  logic start_go, pop, push, full;
  logic op_clear, add_valid, mi_done, acc_done, last_col;
  dbl_t add_a, add_b, add_z;
  logic add_done, add_rst;

  assign last_col = (done_cnt_q + COL_W'(1)) == num_cols_q;

  // Next state and per-cycle controls
  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    start_go  = 1'b0;
    pop       = 1'b0;
    op_clear  = 1'b0;
    add_valid = 1'b0;
    mi_done   = 1'b0;
    acc_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          start_go = 1'b1;
          state_d  = (num_cols == '0) ? RESULT : POP;
        end
      end
      POP: begin
        if (cnt_q != '0) begin
          pop     = 1'b1;
          state_d = ADD_MI;
          ph_d    = PH_CLR;
        end
      end
      ADD_MI, ADD_ACC: begin
        unique case (ph_q)
          PH_CLR: begin
            op_clear = 1'b1;
            ph_d     = PH_ISSUE;
          end
          PH_ISSUE: begin
            add_valid = 1'b1;
            ph_d      = PH_WAIT;
          end
          default: begin
            if (add_done) begin
              ph_d = PH_CLR;
              if (state_q == ADD_MI) begin
                mi_done = 1'b1;
                state_d = ADD_ACC;
              end else begin
                acc_done = 1'b1;
                state_d  = last_col ? RESULT : POP;
              end
            end
          end
        endcase
      end
      RESULT: if (result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A same-cycle pop frees the slot a push needs
  always_comb begin
    full      = (cnt_q == FULL_CNT) && !pop;
    col_ready = !full
             && (state_q inside {POP, ADD_MI, ADD_ACC})
             && (acc_cnt_q < num_cols_q);
    push      = col_valid && col_ready;
    add_a     = (state_q == ADD_ACC) ? acc_q : m_q;
    add_b     = (state_q == ADD_ACC) ? sum_q : i_q;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ph_q    <= PH_CLR;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
    end
  end

  // Column storage, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= '{m: col_m, i: col_i};
  end

  // Counters, pointers, accumulator and result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_cols_q <= '0;
      acc_cnt_q  <= '0;
      done_cnt_q <= '0;
      acc_q      <= DBL_ZERO;
      sum_q      <= DBL_ZERO;
      m_q        <= DBL_ZERO;
      i_q        <= DBL_ZERO;
      result_q   <= DBL_ZERO;
      ovf_q      <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else if (start_go) begin
      num_cols_q <= num_cols;
      acc_cnt_q  <= '0;
      done_cnt_q <= '0;
      acc_q      <= DBL_ZERO;
      ovf_q      <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      if (num_cols == '0) result_q <= DBL_ZERO;
    end else begin
      if (col_valid && !col_ready) ovf_q <= 1'b1;
      if (push) begin
        wr_q      <= wr_q + PW'(1);
        acc_cnt_q <= acc_cnt_q + COL_W'(1);
      end
      if (pop) begin
        m_q  <= mem_q[rd_q].m;
        i_q  <= mem_q[rd_q].i;
        rd_q <= rd_q + PW'(1);
      end
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      if (mi_done) sum_q <= add_z;
      if (acc_done) begin
        acc_q      <= add_z;
        done_cnt_q <= done_cnt_q + COL_W'(1);
        if (last_col) result_q <= add_z;
      end
    end
  end

  assign add_rst = ~rst_n | op_clear;

  double_add u_add (
    .clk         (clk),
    .reset       (add_rst),
    .input_a     (add_a),
    .input_b     (add_b),
    .input_valid (add_valid),
    .output_z    (add_z),
    .output_done (add_done)
  );

  assign result       = result_q;
  assign result_valid = (state_q == RESULT);
  assign busy         = (state_q != IDLE);
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_final_row_accumulator.sv
// Directed bench for final_row_accumulator.
// Expected results queued at start, checked at delivery.
module tb_final_row_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  num_cols;
  logic        col_valid;
  logic [63:0] col_m, col_i;
  logic        col_ready;
  logic [63:0] result;
  logic        result_valid;
  logic        result_ready;
  logic        busy;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] sb_q[$];

  localparam logic [63:0] D1   = 64'h3FF0000000000000;
  localparam logic [63:0] D2   = 64'h4000000000000000;
  localparam logic [63:0] DH   = 64'h3FE0000000000000;
  localparam logic [63:0] DQ   = 64'h3FD0000000000000;

  always #5 clk = ~clk;

  final_row_accumulator #(.FIFO_DEPTH(2), .COL_W(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .num_cols     (num_cols),
    .col_valid    (col_valid),
    .col_m        (col_m),
    .col_i        (col_i),
    .col_ready    (col_ready),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy),
    .overflow     (overflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [9:0] n, input logic [63:0] exp);
    @(negedge clk);
    start    = 1'b1;
    num_cols = n;
    sb_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_col(input logic [63:0] m, input logic [63:0] i);
    int n;
    n = 0;
    while (!col_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("send_timeout", 64'(n >= 300), 64'd0);
    col_valid = 1'b1;
    col_m     = m;
    col_i     = i;
    @(negedge clk);
    col_valid = 1'b0;
  endtask

  task automatic get_result(input string tag);
    int n;
    logic [63:0] exp;
    n = 0;
    while (!result_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hDEAD;
    chk({tag, "_valid"}, 64'(result_valid), 64'd1);
    chk(tag, result, exp);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk({tag, "_drop"}, 64'(result_valid), 64'd0);
    chk({tag, "_hold"}, result, exp);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int acc;
    int guard;
    int n;
    logic saw;

    reset        = 1'b0;
    start        = 1'b0;
    num_cols     = '0;
    col_valid    = 1'b0;
    col_m        = '0;
    col_i        = '0;
    result_ready = 1'b0;

    #12;
    chk("rst_result", result, 64'd0);
    chk("rst_rvalid", 64'(result_valid), 64'd0);
    chk("rst_cready", 64'(col_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    do_start(10'd2, D2);
    send_col(D1, DH);
    send_col(DQ, DQ);
    get_result("basic");

    do_start(10'd2, 64'hBFE8000000000000);
    send_col(D1, 64'hBFD0000000000000);
    send_col(64'hC000000000000000, DH);
    get_result("signed");

    do_start(10'd1, 64'h3FF0000000000002);
    send_col(64'h3FF0000000000001, 64'h3CA0000000000000);
    get_result("round");

    do_start(10'd0, 64'd0);
    chk("zero_rvalid_1cyc", 64'(result_valid), 64'd1);
    chk("zero_cready", 64'(col_ready), 64'd0);
    get_result("zero");

    do_start(10'd4, 64'h4020000000000000);
    acc   = 0;
    guard = 0;
    saw   = 1'b0;
    while (acc < 4 && guard < 400) begin
      if (col_ready) begin
        col_valid = 1'b1;
        col_m     = D1;
        col_i     = D1;
        acc++;
      end else begin
        col_valid = 1'b0;
        saw       = 1'b1;
      end
      @(negedge clk);
      guard++;
    end
    col_valid = 1'b0;
    chk("bp_accepted", 64'(acc), 64'd4);
    chk("bp_seen", 64'(saw), 64'd1);
    get_result("bp");
    chk("bp_ovf", 64'(overflow), 64'd0);

    do_start(10'd2, D2);
    send_col(D1, DH);
    send_col(DQ, DQ);
    col_valid = 1'b1;
    col_m     = D2;
    col_i     = D2;
    chk("ovf_cready", 64'(col_ready), 64'd0);
    @(negedge clk);
    col_valid = 1'b0;
    chk("ovf_set", 64'(overflow), 64'd1);
    get_result("ovf");
    chk("ovf_sticky", 64'(overflow), 64'd1);
    do_start(10'd0, 64'd0);
    chk("ovf_clear", 64'(overflow), 64'd0);
    get_result("ovf_next");

    do_start(10'd1, 64'h4008000000000000);
    send_col(D2, D1);
    n = 0;
    while (!result_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    for (int c = 0; c < 10; c++) begin
      start    = (c == 3);
      num_cols = 10'd0;
      @(negedge clk);
      chk("held_valid", 64'(result_valid), 64'd1);
      chk("held_result", result, 64'h4008000000000000);
    end
    start = 1'b0;
    get_result("held");

    @(negedge clk);
    start    = 1'b1;
    num_cols = 10'd5;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 4; c++) send_col(D1, D1);
    repeat (6) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_result", result, 64'd0);
    chk("mid_rst_rvalid", 64'(result_valid), 64'd0);
    chk("mid_rst_cready", 64'(col_ready), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    do_start(10'd1, D2);
    send_col(D1, D1);
    get_result("after_rst");

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
